// File: rtl/gcd_bridge_pkg.sv
// Shared register map, STATUS bit positions and result width for the GCD Wishbone bridge.
package gcd_bridge_pkg;

  localparam int GCD_W = 16;

  localparam logic [3:0] OFS_OPERANDS = 4'h0;
  localparam logic [3:0] OFS_RESULT   = 4'h4;
  localparam logic [3:0] OFS_STATUS   = 4'h8;

  localparam int ST_REQ_FULL   = 0;
  localparam int ST_REQ_EMPTY  = 1;
  localparam int ST_RESP_FULL  = 2;
  localparam int ST_RESP_EMPTY = 3;
  localparam int ST_OVF        = 4;
  localparam int ST_UDF        = 5;

  function automatic logic [31:0] status_word(input logic req_full, input logic req_empty,
                                              input logic resp_full, input logic resp_empty,
                                              input logic ovf, input logic udf);
    logic [31:0] s;
    s = '0;
    s[ST_REQ_FULL]   = req_full;
    s[ST_REQ_EMPTY]  = req_empty;
    s[ST_RESP_FULL]  = resp_full;
    s[ST_RESP_EMPTY] = resp_empty;
    s[ST_OVF]        = ovf;
    s[ST_UDF]        = udf;
    return s;
  endfunction

endpackage

// File: rtl/gcd_bridge_fifo.sv
// Power-of-two synchronous FIFO with first-word-fall-through head and occupancy counter.
module gcd_bridge_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/gcd_wb_bridge.sv
// Wishbone slave feeding operand pairs to a GCD unit and buffering its results.
// Define GCD_BRIDGE_IRQ_EN to get a registered result-available interrupt on irq.
module gcd_wb_bridge
  import gcd_bridge_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [31:0]      req_msg,
  output logic             req_val,
  input  logic             req_rdy,
  input  logic [GCD_W-1:0] resp_msg,
  input  logic             resp_val,
  output logic             resp_rdy,
  output logic             irq
);

  logic             w_hit;
  logic [3:0]       w_ofs;
  logic             w_wr_ops;
  logic             w_rd_res;
  logic             w_wr_sts;
  logic             w_rd_sts;
  logic             w_req_full;
  logic             w_req_empty;
  logic             w_req_pop;
  logic             w_resp_full;
  logic             w_resp_empty;
  logic             w_resp_push;
  logic [GCD_W-1:0] w_resp_head;
  logic             w_ovf_set;
  logic             w_udf_set;
  logic [31:0]      w_rdata;
  logic             r_ack;
  logic [31:0]      r_dat;
  logic             r_ovf;
  logic             r_udf;

  assign w_ofs    = wbs_adr_i[3:0];
  assign w_hit    = wbs_cyc_i & wbs_stb_i & ~r_ack & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_wr_ops = w_hit & wbs_we_i & (w_ofs == OFS_OPERANDS) & (wbs_sel_i == 4'hF);
  assign w_rd_res = w_hit & ~wbs_we_i & (w_ofs == OFS_RESULT);
  assign w_wr_sts = w_hit & wbs_we_i & (w_ofs == OFS_STATUS);
  assign w_rd_sts = w_hit & ~wbs_we_i & (w_ofs == OFS_STATUS);

  assign w_req_pop   = ~w_req_empty & req_rdy;
  assign w_resp_push = resp_val & ~w_resp_full;
  assign w_ovf_set   = w_wr_ops & w_req_full & ~w_req_pop;
  assign w_udf_set   = w_rd_res & w_resp_empty;

  gcd_bridge_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_req_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_wr_ops),
    .i_data  (wbs_dat_i),
    .i_pop   (w_req_pop),
    .o_full  (w_req_full),
    .o_empty (w_req_empty),
    .o_head  (req_msg)
  );

  gcd_bridge_fifo #(.WIDTH(GCD_W), .DEPTH(FIFO_DEPTH)) u_resp_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_resp_push),
    .i_data  (resp_msg),
    .i_pop   (w_rd_res),
    .o_full  (w_resp_full),
    .o_empty (w_resp_empty),
    .o_head  (w_resp_head)
  );

  assign req_val  = ~w_req_empty;
  assign resp_rdy = ~w_resp_full;

  // Zero unless this cycle accepts a read, so the registered bus data idles at 0.
  always_comb begin
    w_rdata = '0;
    if (w_rd_res && !w_resp_empty) begin
      w_rdata = {{(32-GCD_W){1'b0}}, w_resp_head};
    end else if (w_rd_sts) begin
      w_rdata = status_word(w_req_full, w_req_empty, w_resp_full, w_resp_empty, r_ovf, r_udf);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ack <= w_hit;
      r_dat <= w_rdata;
      if (w_ovf_set)                            r_ovf <= 1'b1;
      else if (w_wr_sts && wbs_dat_i[ST_OVF])   r_ovf <= 1'b0;
      if (w_udf_set)                            r_udf <= 1'b1;
      else if (w_wr_sts && wbs_dat_i[ST_UDF])   r_udf <= 1'b0;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

`ifdef GCD_BRIDGE_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= ~w_resp_empty;
  end
  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_wb_bridge.sv
// Self-checking bench for gcd_wb_bridge: register vectors, GCD scoreboard and handshake corners.
module tb_gcd_wb_bridge;
  import gcd_bridge_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef GCD_BRIDGE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] req_msg;
  logic        req_val, req_rdy;
  logic [15:0] resp_msg;
  logic        resp_val, resp_rdy;
  logic        irq;

  gcd_wb_bridge #(.FIFO_DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy),
    .resp_msg(resp_msg), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [31:0] req_q[$];

  typedef struct {
    logic        we;
    logic [3:0]  ofs;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] gcd16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic wb_start(input logic we, input logic [3:0] ofs, input logic [31:0] dat,
                          input logic [3:0] sel);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = BASE | {28'h0, ofs};
    wbs_dat_i = dat;
    wbs_sel_i = sel;
  endtask

  task automatic wb_finish(output logic [31:0] rd);
    int lat;
    lat = 0;
    rd  = '0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      if (wbs_ack_o) begin
        lat = n;
        rd  = wbs_dat_o;
      end
    end
    check("ack_latency", lat, 1);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    @(negedge clk);
    check("ack_single", wbs_ack_o, 0);
    check("dat_idle", wbs_dat_o, 0);
  endtask

  task automatic wb(input logic we, input logic [3:0] ofs, input logic [31:0] dat,
                    input logic [3:0] sel, output logic [31:0] rd);
    @(negedge clk);
    wb_start(we, ofs, dat, sel);
    wb_finish(rd);
  endtask

  task automatic wr(input string nm, input logic [3:0] ofs, input logic [31:0] dat);
    logic [31:0] rd;
    wb(1'b1, ofs, dat, 4'hF, rd);
    check(nm, rd, 0);
  endtask

  task automatic rd_status(input string nm, input logic [31:0] exp);
    logic [31:0] rd;
    wb(1'b0, OFS_STATUS, 0, 4'hF, rd);
    check(nm, rd, exp);
  endtask

  task automatic read_result(input string nm);
    logic [31:0] rd, exp;
    exp = (exp_q.size() > 0) ? {16'h0, exp_q.pop_front()} : 32'h0;
    wb(1'b0, OFS_RESULT, 0, 4'hF, rd);
    check(nm, rd, exp);
  endtask

  task automatic push_resp(input logic [15:0] v, input bit track);
    check("push_resp_rdy", resp_rdy, 1);
    resp_val = 1'b1;
    resp_msg = v;
    @(negedge clk);
    resp_val = 1'b0;
    if (track) exp_q.push_back(v);
  endtask

  task automatic gcd_serve();
    int w;
    logic [31:0] m;
    w = 0;
    while (!req_val && w < 10) begin @(negedge clk); w++; end
    check("serve_req_val", req_val, 1);
    if (req_val) begin
      m = req_msg;
      req_rdy = 1'b1;
      @(negedge clk);
      req_rdy  = 1'b0;
      resp_msg = gcd16(m[31:16], m[15:0]);
      resp_val = 1'b1;
      w = 0;
      while (!resp_rdy && w < 10) begin @(negedge clk); w++; end
      @(negedge clk);
      resp_val = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] ops [3];
    int acks;

    reset = 1'b1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0;
    req_rdy = 0; resp_val = 0; resp_msg = 0;

    vecs[0] = '{1'b0, OFS_STATUS,   32'h0,         4'hF, 32'h0000_000A};
    vecs[1] = '{1'b0, 4'hC,         32'h0,         4'hF, 32'h0};
    vecs[2] = '{1'b1, 4'hC,         32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[3] = '{1'b1, OFS_OPERANDS, 32'h1234_5678, 4'h3, 32'h0};
    vecs[4] = '{1'b0, OFS_STATUS,   32'h0,         4'hF, 32'h0000_000A};
    vecs[5] = '{1'b0, OFS_OPERANDS, 32'h0,         4'hF, 32'h0};
    vecs[6] = '{1'b1, OFS_RESULT,   32'h0000_DEAD, 4'hF, 32'h0};
    vecs[7] = '{1'b0, 4'h2,         32'h0,         4'hF, 32'h0};
    vecs[8] = '{1'b1, OFS_STATUS,   32'h0000_0030, 4'hF, 32'h0};
    vecs[9] = '{1'b0, OFS_STATUS,   32'h0,         4'hF, 32'h0000_000A};

    repeat (3) @(negedge clk);
    check("rst_ack", wbs_ack_o, 0);
    check("rst_dat", wbs_dat_o, 0);
    check("rst_req_val", req_val, 0);
    check("rst_irq", irq, 0);
    check("rst_resp_rdy", resp_rdy, 1);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      wb(vecs[i].we, vecs[i].ofs, vecs[i].dat, vecs[i].sel, rd);
      check($sformatf("vec%0d", i), rd, vecs[i].exp);
    end
    check("vec_req_val", req_val, 0);

    // Access outside the decoded window must never be acknowledged.
    @(negedge clk);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE + 32'h10;
    acks = 0;
    repeat (4) begin @(negedge clk); if (wbs_ack_o) acks++; end
    check("foreign_addr_ack", acks, 0);
    wbs_cyc_i = 0; wbs_stb_i = 0;

    // Single operand pair through a modelled GCD unit.
    wr("ops_wr", OFS_OPERANDS, 32'h0030_0012);
    check("ops_req_val", req_val, 1);
    check("ops_req_msg", req_msg, 32'h0030_0012);
    repeat (3) @(negedge clk);
    check("ops_req_msg_hold", req_msg, 32'h0030_0012);
    gcd_serve();
    wb(1'b0, OFS_RESULT, 0, 4'hF, rd);
    check("result_6", rd, 32'h0000_0006);

    // Scoreboard over several queued pairs.
    ops[0] = 32'h0015_0023; ops[1] = 32'h1000_0800; ops[2] = 32'h0011_0000;
    for (int i = 0; i < 3; i++) begin
      wr("sb_wr", OFS_OPERANDS, ops[i]);
      exp_q.push_back(gcd16(ops[i][31:16], ops[i][15:0]));
    end
    for (int i = 0; i < 3; i++) gcd_serve();
    for (int i = 0; i < 3; i++) read_result($sformatf("sb_result%0d", i));

    // Overflow: one pending result keeps resp_empty low so STATUS reads 0x11.
    @(negedge clk);
    push_resp(16'h00AB, 1);
    for (int i = 0; i < 5; i++) begin
      wr("ovf_wr", OFS_OPERANDS, 32'hA000_0000 + i);
      if (i < 4) req_q.push_back(32'hA000_0000 + i);
    end
    rd_status("ovf_status", 32'h0000_0011);
    wr("ovf_clr", OFS_STATUS, 32'h0000_0010);
    rd_status("ovf_cleared", 32'h0000_0001);
    @(negedge clk);
    req_rdy = 1'b1;
    wb_start(1'b1, OFS_OPERANDS, 32'hA000_0005, 4'hF);
    fork begin @(negedge clk); req_rdy = 1'b0; end join_none
    wb_finish(rd);
    void'(req_q.pop_front());
    req_q.push_back(32'hA000_0005);
    rd_status("full_pop_push", 32'h0000_0001);
    while (req_q.size() > 0) begin
      check("drain_val", req_val, 1);
      check("drain_msg", req_msg, req_q.pop_front());
      req_rdy = 1'b1;
      @(negedge clk);
      req_rdy = 1'b0;
    end
    check("drain_empty", req_val, 0);
    read_result("ovf_pending_result");
    rd_status("after_drain", 32'h0000_000A);

    // Underflow on an empty result FIFO.
    read_result("udf_read");
    rd_status("udf_status", 32'h0000_002A);
    wr("udf_clr", OFS_STATUS, 32'h0000_0020);
    rd_status("udf_cleared", 32'h0000_000A);

    // Empty RESULT read coinciding with a result push keeps the new entry.
    @(negedge clk);
    resp_val = 1'b1; resp_msg = 16'h0055;
    wb_start(1'b0, OFS_RESULT, 0, 4'hF);
    fork begin @(negedge clk); resp_val = 1'b0; end join_none
    wb_finish(rd);
    check("race_read", rd, 0);
    rd_status("race_status", 32'h0000_0022);
    exp_q.push_back(16'h0055);
    read_result("race_retained");
    wr("race_clr", OFS_STATUS, 32'h0000_0020);

    // Result FIFO back-pressure.
    @(negedge clk);
    resp_val = 1'b1;
    for (int k = 0; k < 6; k++) begin
      resp_msg = 16'h0100 + 16'(k);
      check($sformatf("resp_rdy_fill%0d", k), resp_rdy, (k < 4) ? 1 : 0);
      if (resp_rdy) exp_q.push_back(resp_msg);
      @(negedge clk);
    end
    rd_status("resp_full_status", 32'h0000_0006);
    @(negedge clk);
    wb_start(1'b0, OFS_RESULT, 0, 4'hF);
    fork begin @(negedge clk); check("resp_rdy_back", resp_rdy, 1); resp_val = 1'b0; end join_none
    wb_finish(rd);
    check("bp_result0", rd, {16'h0, exp_q.pop_front()});
    for (int i = 1; i < 4; i++) read_result($sformatf("bp_result%0d", i));
    rd_status("bp_status", 32'h0000_000A);

    // Interrupt timing.
    @(negedge clk);
    check("irq_idle", irq, 0);
    resp_val = 1'b1; resp_msg = 16'h0077;
    @(negedge clk);
    resp_val = 1'b0;
    check("irq_push_edge", irq, 0);
    @(negedge clk);
    check("irq_raised", irq, IRQ_ON);
    exp_q.push_back(16'h0077);
    wb_start(1'b0, OFS_RESULT, 0, 4'hF);
    fork begin @(negedge clk); check("irq_pop_edge", irq, IRQ_ON); end join_none
    wb_finish(rd);
    check("irq_result", rd, {16'h0, exp_q.pop_front()});
    check("irq_cleared", irq, 0);

    // Reset between acceptance and ack.
    wr("abort_fill", OFS_OPERANDS, 32'h1111_2222);
    push_resp(16'h0009, 0);
    @(negedge clk);
    wb_start(1'b1, OFS_OPERANDS, 32'h3333_4444, 4'hF);
    #2;
    reset = 1'b1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    @(negedge clk);
    check("abort_ack", wbs_ack_o, 0);
    check("abort_req_val", req_val, 0);
    check("abort_resp_rdy", resp_rdy, 1);
    check("abort_irq", irq, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("abort_ack_after", wbs_ack_o, 0);
    rd_status("abort_status", 32'h0000_000A);
    wr("post_reset_wr", OFS_OPERANDS, 32'h0007_0003);
    check("post_reset_msg", req_msg, 32'h0007_0003);
    exp_q.push_back(gcd16(16'h0007, 16'h0003));
    gcd_serve();
    read_result("post_reset_result");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
